encoder8x3_arb: RTL and testbench
=================================

ENCODER8X3_ARB -- requirements
Module: encoder8x3_arb

Interface
REQ-001 Parameter: N, 8, number of request lines; only 8 is supported.
REQ-002 Parameter: W, 3, code width; SHALL equal clog2(N).
REQ-003 Port: CLK  input  1  single clock; all state updates on rising edge.
REQ-004 Port: RST  input  1  reset, synchronous, active-high.
REQ-005 Port: EN  input  1  request enable; when 0, I is ignored.
REQ-006 Port: I  input  N  request lines, bit k = source k; sampled every cycle.
REQ-007 Port: ACK  input  1  consumer accepts current code (valid only with V=1).
REQ-008 Port: Y  output  W  registered binary code of the granted source.
REQ-009 Port: V  output  1  registered; Y holds a valid, unaccepted code.
REQ-010 Port: PEND  output  N  registered pending-request vector.
REQ-011 Port: OVF  output  1  registered one-cycle pulse: request merged into an already-pending bit.

Function
REQ-012 Pending update per edge: PEND <= (PEND & ~CLR) | (I & {N{EN}}), CLR = one-hot of the bit granted this cycle (zero if none).
REQ-013 Set wins: a request on bit k in the same cycle bit k is granted SHALL leave PEND[k]=1.
REQ-014 Priority: grant SHALL select the highest-index set bit of the registered PEND; I of the current cycle is not visible to the grant.
REQ-015 FSM states: IDLE (V=0) and HOLD (V=1).
REQ-016 IDLE, PEND!=0: load Y=granted index, V<=1, clear that bit, go HOLD.
REQ-017 IDLE, PEND==0: remain IDLE, Y holds previous value, V=0.
REQ-018 HOLD, ACK=0: Y and V SHALL remain stable; no grant, no clear.
REQ-019 HOLD, ACK=1, PEND!=0: back-to-back load of next grant in the same edge, V stays 1, remain HOLD.
REQ-020 HOLD, ACK=1, PEND==0: V<=0, go IDLE.
REQ-021 ACK while V=0 SHALL be ignored.
REQ-022 Latency: request on I at edge t (EN=1, FSM IDLE, PEND empty) -> PEND set at edge t, Y/V valid after edge t+1 (2 cycles from request to V).
REQ-023 Throughput: with ACK held 1 and PEND non-empty, one code per cycle.
REQ-024 OVF<=1 for one cycle when any k has I[k]&EN&PEND[k] and bit k is not being cleared that cycle; else OVF<=0.
REQ-025 EN=0: no new requests; existing PEND and HOLD output continue draining normally.
REQ-026 Multiple simultaneous requests SHALL all be captured in PEND and served highest-index first, one per grant.

Reset
REQ-027 RST=1 at an edge: PEND=0, Y=0, V=0, OVF=0, FSM=IDLE; I and ACK ignored that cycle.
REQ-028 RST mid-operation (HOLD or non-empty PEND) SHALL discard all pending and held codes; no grant on the reset edge.
REQ-029 First request sampled on the first edge with RST=0.

Structure
REQ-030 Shared package encoder_pkg SHALL hold N, W and the FSM state type (IDLE, HOLD).
REQ-031 One combinational sub-module prio_enc8x3: input 8-bit vector, outputs 3-bit highest-index code and any-set flag; instantiated once on PEND.
REQ-032 No latches; all outputs driven from flops.

Verification
REQ-033 Reset: hold RST=1 with I=8'hFF, EN=1 -> after release PEND=0, V=0, Y=0, OVF=0.
REQ-034 Single: I=8'h20 one cycle, ACK=0 -> PEND=8'h20 next edge, then Y=5, V=1, PEND=0; stable until ACK; ACK -> V=0.
REQ-035 Burst: I=8'h91 one cycle, ACK=1 continuously -> Y sequence 7,4,0 on consecutive cycles, then V=0, PEND=0.
REQ-036 Merge/OVF: I=8'h04 twice while PEND[2]=1 and held -> OVF pulses once, one Y=2 served only.
REQ-037 Set-wins: I[3]=1 on the same edge bit 3 is granted -> PEND[3] remains 1, Y=3 served twice.
REQ-038 EN gating and mid-op reset: EN=0 with I=8'hFF -> PEND unchanged; RST during HOLD with PEND=8'h0A -> V=0, PEND=0 next cycle.

Source files
------------

// File: rtl/encoder8x3_arb_pkg.sv
// Shared sizing constants and FSM state type for the 8-to-3 arbitrating encoder.
package encoder_pkg;
    localparam int N = 8;
    localparam int W = $clog2(N);

    typedef enum logic {
        IDLE = 1'b0,
        HOLD = 1'b1
    } state_t;
endpackage

// File: rtl/encoder8x3_arb_if.sv
// Request/grant bus between a request source/consumer (master) and the arbiter (slave).
interface encoder8x3_arb_if #(
    parameter int N = encoder_pkg::N,
    parameter int W = encoder_pkg::W
) ();
    logic         EN;
    logic [N-1:0] I;
    logic         ACK;
    logic [W-1:0] Y;
    logic         V;
    logic [N-1:0] PEND;
    logic         OVF;

    modport master (
        output EN, I, ACK,
        input  Y, V, PEND, OVF
    );

    modport slave (
        input  EN, I, ACK,
        output Y, V, PEND, OVF
    );
endinterface

// File: rtl/encoder8x3_arb_prio_enc8x3.sv
// Combinational highest-index-first priority encoder over an 8-bit vector.
module prio_enc8x3 (
    input  logic [7:0] vec,
    output logic [2:0] code,
    output logic       any
);
    always_comb begin
        code = 3'd0;
        any  = 1'b0;
        // Ascending scan so the highest set index is the last one written.
        for (int k = 0; k < 8; k++) begin
            if (vec[k]) begin
                code = 3'(k);
                any  = 1'b1;
            end
        end
    end
endmodule

// File: rtl/encoder8x3_arb.sv
// Pending-request arbiter: captures requests into PEND, serves them highest index first
// as a registered code with a valid/accept handshake, and flags merged requests on OVF.
module encoder8x3_arb #(
    parameter int N = encoder_pkg::N,
    parameter int W = encoder_pkg::W
) (
    input  logic             CLK,
    input  logic             RST,
    encoder8x3_arb_if.slave  bus
);
    import encoder_pkg::*;

    state_t       state;
    logic [W-1:0] code;
    logic         any;
    logic         do_grant;
    logic [N-1:0] clr;
    logic [N-1:0] set;

    prio_enc8x3 u_prio (
        .vec  (bus.PEND),
        .code (code),
        .any  (any)
    );

    // Grant only from the registered PEND; a held code blocks new grants until accepted.
    always_comb begin
        do_grant = any && ((state == IDLE) || bus.ACK);
        clr      = '0;
        clr[code] = do_grant;
        set      = bus.I & {N{bus.EN}};
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state    <= IDLE;
            bus.PEND <= '0;
            bus.Y    <= '0;
            bus.V    <= 1'b0;
            bus.OVF  <= 1'b0;
        end else begin
            bus.PEND <= (bus.PEND & ~clr) | set;
            bus.OVF  <= |(set & bus.PEND & ~clr);
            case (state)
                IDLE: begin
                    if (any) begin
                        bus.Y <= code;
                        bus.V <= 1'b1;
                        state <= HOLD;
                    end
                end
                HOLD: begin
                    if (bus.ACK) begin
                        if (any) begin
                            bus.Y <= code;
                        end else begin
                            bus.V <= 1'b0;
                            state <= IDLE;
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                    bus.V <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_encoder8x3_arb.sv
// Scoreboard bench: expected codes are queued by the stimulus, popped on each accepted code.
module tb_encoder8x3_arb;
    logic CLK = 1'b0;
    logic RST;

    encoder8x3_arb_if bus ();

    encoder8x3_arb dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus)
    );

    always #5 CLK = ~CLK;

    int compared   = 0;
    int mismatched = 0;
    logic [2:0] exp_q[$];

    task automatic check(input string name, input int act, input int exp);
        compared++;
        if (act != exp) begin
            mismatched++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    // Monitor: a code is consumed when V and ACK are both high going into the next edge.
    always @(negedge CLK) begin
        if (!RST && bus.V && bus.ACK) begin
            if (exp_q.size() == 0) begin
                compared++;
                mismatched++;
                $display("FAIL unexpected_code: got %0d expected none", bus.Y);
            end else begin
                check("served_code", int'(bus.Y), int'(exp_q.pop_front()));
            end
        end
    end

    initial begin
        RST = 1'b1;
        bus.EN = 1'b1;
        bus.I = 8'hFF;
        bus.ACK = 1'b1;
        repeat (3) tick();
        check("rst_pend", bus.PEND, 8'h00);
        check("rst_v", bus.V, 0);
        check("rst_y", bus.Y, 0);
        check("rst_ovf", bus.OVF, 0);
        RST = 1'b0;
        bus.I = 8'h00;
        bus.ACK = 1'b0;
        tick();
        check("post_rst_pend", bus.PEND, 8'h00);

        // Single request, held until accepted
        bus.I = 8'h20;
        tick();
        check("single_pend", bus.PEND, 8'h20);
        check("single_v0", bus.V, 0);
        bus.I = 8'h00;
        tick();
        check("single_y", bus.Y, 5);
        check("single_v", bus.V, 1);
        check("single_pend_clr", bus.PEND, 8'h00);
        repeat (3) tick();
        check("single_hold_y", bus.Y, 5);
        check("single_hold_v", bus.V, 1);
        exp_q.push_back(3'd5);
        bus.ACK = 1'b1;
        tick();
        check("single_ack_v", bus.V, 0);
        bus.ACK = 1'b0;

        // Burst 0x91 with ACK held: 7,4,0 back to back
        exp_q.push_back(3'd7);
        exp_q.push_back(3'd4);
        exp_q.push_back(3'd0);
        bus.I = 8'h91;
        bus.ACK = 1'b1;
        tick();
        check("burst_pend", bus.PEND, 8'h91);
        bus.I = 8'h00;
        tick();
        check("burst_y7", bus.Y, 7);
        check("burst_pend1", bus.PEND, 8'h11);
        tick();
        check("burst_y4", bus.Y, 4);
        check("burst_v4", bus.V, 1);
        tick();
        check("burst_y0", bus.Y, 0);
        check("burst_pend3", bus.PEND, 8'h00);
        tick();
        check("burst_v_end", bus.V, 0);
        bus.ACK = 1'b0;

        // Merge: bit 2 re-requested while pending behind a held code 7
        bus.I = 8'h84;
        tick();
        bus.I = 8'h00;
        tick();
        check("merge_y7", bus.Y, 7);
        check("merge_pend", bus.PEND, 8'h04);
        check("merge_ovf0", bus.OVF, 0);
        bus.I = 8'h04;
        tick();
        check("merge_ovf1", bus.OVF, 1);
        check("merge_pend_kept", bus.PEND, 8'h04);
        bus.I = 8'h00;
        tick();
        check("merge_ovf_pulse", bus.OVF, 0);
        exp_q.push_back(3'd7);
        exp_q.push_back(3'd2);
        bus.ACK = 1'b1;
        tick();
        check("merge_y2", bus.Y, 2);
        tick();
        check("merge_v_end", bus.V, 0);
        check("merge_pend_end", bus.PEND, 8'h00);
        bus.ACK = 1'b0;

        // Set wins: bit 3 requested on the edge it is granted
        bus.I = 8'h08;
        tick();
        tick();
        check("setwin_y", bus.Y, 3);
        check("setwin_pend", bus.PEND, 8'h08);
        check("setwin_ovf", bus.OVF, 0);
        bus.I = 8'h00;
        exp_q.push_back(3'd3);
        exp_q.push_back(3'd3);
        bus.ACK = 1'b1;
        tick();
        check("setwin_y2", bus.Y, 3);
        check("setwin_v2", bus.V, 1);
        tick();
        check("setwin_v_end", bus.V, 0);
        bus.ACK = 1'b0;

        // EN gating, then reset while holding with PEND=0x0A
        bus.I = 8'h8A;
        tick();
        bus.EN = 1'b0;
        bus.I = 8'hFF;
        tick();
        check("en_y7", bus.Y, 7);
        check("en_pend", bus.PEND, 8'h0A);
        check("en_ovf", bus.OVF, 0);
        tick();
        check("en_pend_hold", bus.PEND, 8'h0A);
        RST = 1'b1;
        tick();
        check("midrst_v", bus.V, 0);
        check("midrst_pend", bus.PEND, 8'h00);
        check("midrst_y", bus.Y, 0);
        RST = 1'b0;
        bus.EN = 1'b1;
        bus.I = 8'h00;
        tick();
        check("midrst_v_after", bus.V, 0);
        tick();

        check("queue_drained", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
